// File: rtl/sdram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arb_pkg
// Description : Shared types and defaults for the SDRAM access arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_arb_pkg;

    localparam int SDRAM_ARB_ADDR_W = 22;
    localparam int SDRAM_ARB_DATA_W = 16;
    localparam int STARVE_W         = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RD_WAIT = 2'd1,
        ST_WR_WAIT = 2'd2
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/sdram_arb_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : sdram_arb_watchdog
// Description : Transaction timeout counter; expire_o flags the last allowed
//               cycle so the owner can abort on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_arb_watchdog #(
    parameter int WD_CYCLES = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam int CNT_W = (WD_CYCLES < 2) ? 1 : $clog2(WD_CYCLES);
    localparam logic [CNT_W-1:0] c_limit = CNT_W'(WD_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != c_limit)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expire_o = enable_i && !clear_i && (cnt_q == c_limit);

endmodule
`default_nettype wire

// File: rtl/sdram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sdram_access_arbiter
// Description : Shares the sdram_controller command port between the TFT
//               line-fetch reader and the pixel FIFO writer, read-favoured
//               with bounded write starvation. Optional transaction watchdog
//               enabled by defining SDRAM_ARB_WATCHDOG_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_access_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W     = SDRAM_ARB_ADDR_W,
    parameter int DATA_W     = SDRAM_ARB_DATA_W,
    parameter int STARVE_MAX = 8,
    parameter int WD_CYCLES  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_gnt_o,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_gnt_o,
    output logic              wr_done_o,
    input  logic              ctl_busy_i,
    output logic              ctl_rd_enable_o,
    output logic              ctl_wr_enable_o,
    output logic [ADDR_W-1:0] ctl_addr_o,
    output logic [DATA_W-1:0] ctl_wr_data_o,
    input  logic              ctl_rd_valid_i,
    input  logic [DATA_W-1:0] ctl_rd_data_i,
    input  logic              ctl_wr_ack_i,
    output logic              err_o
);

    localparam logic [STARVE_W-1:0] c_starve_max = STARVE_W'(STARVE_MAX);

    if ((STARVE_MAX < 1) || (STARVE_MAX > 15)) begin : g_bad_starve_max
        $error("STARVE_MAX must be in 1..15");
    end
    if (WD_CYCLES < 1) begin : g_bad_wd_cycles
        $error("WD_CYCLES must be at least 1");
    end

    arb_state_e          state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                rd_gnt_q, rd_gnt_d;
    logic                wr_gnt_q, wr_gnt_d;
    logic [ADDR_W-1:0]   ctl_addr_q, ctl_addr_d;
    logic [DATA_W-1:0]   ctl_wr_data_q, ctl_wr_data_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                rd_valid_q, rd_valid_d;
    logic                wr_done_q, wr_done_d;
    logic                err_q, err_d;

    logic                w_idle;
    logic                w_issue;
    logic                w_pick_wr;
    logic                w_wd_expire;

    assign w_idle    = (state_q == ST_IDLE);
    assign w_issue   = w_idle && !ctl_busy_i && (rd_req_i || wr_req_i);
    assign w_pick_wr = wr_req_i && (!rd_req_i || (starve_q == c_starve_max));

`ifdef SDRAM_ARB_WATCHDOG_EN
    // Counter is held clear while idle, so every WAIT entry starts from zero.
    sdram_arb_watchdog #(
        .WD_CYCLES (WD_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (w_idle),
        .enable_i (!w_idle),
        .expire_o (w_wd_expire)
    );
`else
    assign w_wd_expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            starve_q      <= '0;
            rd_gnt_q      <= 1'b0;
            wr_gnt_q      <= 1'b0;
            ctl_addr_q    <= '0;
            ctl_wr_data_q <= '0;
            rd_data_q     <= '0;
            rd_valid_q    <= 1'b0;
            wr_done_q     <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            starve_q      <= starve_d;
            rd_gnt_q      <= rd_gnt_d;
            wr_gnt_q      <= wr_gnt_d;
            ctl_addr_q    <= ctl_addr_d;
            ctl_wr_data_q <= ctl_wr_data_d;
            rd_data_q     <= rd_data_d;
            rd_valid_q    <= rd_valid_d;
            wr_done_q     <= wr_done_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        starve_d      = starve_q;
        rd_gnt_d      = 1'b0;
        wr_gnt_d      = 1'b0;
        ctl_addr_d    = ctl_addr_q;
        ctl_wr_data_d = ctl_wr_data_q;
        rd_data_d     = rd_data_q;
        rd_valid_d    = 1'b0;
        wr_done_d     = 1'b0;
        err_d         = err_q;

        case (state_q)
            ST_IDLE: begin
                if (w_issue) begin
                    if (w_pick_wr) begin
                        wr_gnt_d      = 1'b1;
                        ctl_addr_d    = wr_addr_i;
                        ctl_wr_data_d = wr_data_i;
                        starve_d      = '0;
                        state_d       = ST_WR_WAIT;
                    end else begin
                        rd_gnt_d   = 1'b1;
                        ctl_addr_d = rd_addr_i;
                        state_d    = ST_RD_WAIT;
                        // Only reads that overtake a waiting write count.
                        if (wr_req_i && (starve_q != c_starve_max)) begin
                            starve_d = starve_q + 1'b1;
                        end
                    end
                end
            end

            ST_RD_WAIT: begin
                if (ctl_rd_valid_i) begin
                    rd_data_d  = ctl_rd_data_i;
                    rd_valid_d = 1'b1;
                    state_d    = ST_IDLE;
                end else if (w_wd_expire) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            ST_WR_WAIT: begin
                if (ctl_wr_ack_i) begin
                    wr_done_d = 1'b1;
                    state_d   = ST_IDLE;
                end else if (w_wd_expire) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Grant and command strobe are the same event seen from two sides.
    assign rd_gnt_o        = rd_gnt_q;
    assign ctl_rd_enable_o = rd_gnt_q;
    assign wr_gnt_o        = wr_gnt_q;
    assign ctl_wr_enable_o = wr_gnt_q;
    assign ctl_addr_o      = ctl_addr_q;
    assign ctl_wr_data_o   = ctl_wr_data_q;
    assign rd_data_o       = rd_data_q;
    assign rd_valid_o      = rd_valid_q;
    assign wr_done_o       = wr_done_q;
    assign err_o           = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_access_arbiter
// Description : Scoreboard bench for sdram_access_arbiter (default build and
//               SDRAM_ARB_WATCHDOG_EN build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_access_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rd_req = 1'b0;
    logic [21:0] rd_addr = '0;
    logic        wr_req = 1'b0;
    logic [21:0] wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        ctl_busy = 1'b0;
    logic        ctl_rd_valid = 1'b0;
    logic [15:0] ctl_rd_data = '0;
    logic        ctl_wr_ack = 1'b0;

    logic        rd_gnt_o, rd_valid_o, wr_gnt_o, wr_done_o;
    logic        ctl_rd_enable_o, ctl_wr_enable_o, err_o;
    logic [15:0] rd_data_o, ctl_wr_data_o;
    logic [21:0] ctl_addr_o;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [7:0]  kind;
        logic [21:0] addr;
        logic [15:0] data;
    } ev_t;

    ev_t exp_q[$];

    sdram_access_arbiter #(
        .ADDR_W     (22),
        .DATA_W     (16),
        .STARVE_MAX (8),
        .WD_CYCLES  (255)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .rd_req_i        (rd_req),
        .rd_addr_i       (rd_addr),
        .rd_gnt_o        (rd_gnt_o),
        .rd_data_o       (rd_data_o),
        .rd_valid_o      (rd_valid_o),
        .wr_req_i        (wr_req),
        .wr_addr_i       (wr_addr),
        .wr_data_i       (wr_data),
        .wr_gnt_o        (wr_gnt_o),
        .wr_done_o       (wr_done_o),
        .ctl_busy_i      (ctl_busy),
        .ctl_rd_enable_o (ctl_rd_enable_o),
        .ctl_wr_enable_o (ctl_wr_enable_o),
        .ctl_addr_o      (ctl_addr_o),
        .ctl_wr_data_o   (ctl_wr_data_o),
        .ctl_rd_valid_i  (ctl_rd_valid),
        .ctl_rd_data_i   (ctl_rd_data),
        .ctl_wr_ack_i    (ctl_wr_ack),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    function automatic ev_t mk(input logic [7:0] k, input logic [21:0] a, input logic [15:0] d);
        ev_t e;
        e.kind = k;
        e.addr = a;
        e.data = d;
        return e;
    endfunction

    // Scoreboard: every DUT event pops the oldest expectation.
    task automatic sb_pop(input logic [7:0] k, input logic [21:0] a, input logic [15:0] d);
        ev_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got event %c addr %h data %h, required no event", k, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== k || e.addr !== a || e.data !== d) begin
                n_fail++;
                $display("FAIL sb_event: got %c addr %h data %h, required %c addr %h data %h",
                         k, a, d, e.kind, e.addr, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (rd_gnt_o || ctl_rd_enable_o)
            sb_pop((rd_gnt_o && ctl_rd_enable_o) ? "R" : "r", ctl_addr_o, 16'h0);
        if (wr_gnt_o || ctl_wr_enable_o)
            sb_pop((wr_gnt_o && ctl_wr_enable_o) ? "W" : "w", ctl_addr_o, ctl_wr_data_o);
        if (rd_valid_o)
            sb_pop("V", 22'h0, rd_data_o);
        if (wr_done_o)
            sb_pop("D", 22'h0, 16'h0);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // which: 0 rd_gnt, 1 wr_gnt, 4 either grant
    task automatic wait_gnt(input int which, input string name);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if ((which == 0 && rd_gnt_o) || (which == 1 && wr_gnt_o) ||
                (which == 4 && (rd_gnt_o || wr_gnt_o)))
                seen = 1;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no grant in 40 cycles, required a grant", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        tick(3);
        n_tests++;
        if ({rd_gnt_o, wr_gnt_o, ctl_rd_enable_o, ctl_wr_enable_o, rd_valid_o, wr_done_o, err_o} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b, required 0000000",
                     {rd_gnt_o, wr_gnt_o, ctl_rd_enable_o, ctl_wr_enable_o, rd_valid_o, wr_done_o, err_o});
        end
        n_tests++;
        if (ctl_addr_o !== 22'h0) begin
            n_fail++;
            $display("FAIL reset_ctl_addr: got %h, required 000000", ctl_addr_o);
        end
        n_tests++;
        if (ctl_wr_data_o !== 16'h0 || rd_data_o !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_data: got wr %h rd %h, required 0000 0000", ctl_wr_data_o, rd_data_o);
        end
        rst = 1'b1;
        tick(2);
    endtask

    task automatic test_single_read();
        exp_q.push_back(mk("R", 22'h12345, 16'h0));
        exp_q.push_back(mk("V", 22'h0, 16'hF81F));
        rd_addr = 22'h12345;
        rd_req  = 1'b1;
        wait_gnt(0, "single_read");
        rd_req = 1'b0;
        n_tests++;
        if (ctl_addr_o !== 22'h12345) begin
            n_fail++;
            $display("FAIL single_read_addr: got %h, required 012345", ctl_addr_o);
        end
        tick(2);
        ctl_rd_valid = 1'b1;
        ctl_rd_data  = 16'hF81F;
        tick(1);
        ctl_rd_valid = 1'b0;
        ctl_rd_data  = 16'h0;
        n_tests++;
        if (rd_valid_o !== 1'b1 || rd_data_o !== 16'hF81F) begin
            n_fail++;
            $display("FAIL single_read_data: got valid %b data %h, required 1 f81f", rd_valid_o, rd_data_o);
        end
        tick(3);
        n_tests++;
        if (rd_valid_o !== 1'b0 || rd_data_o !== 16'hF81F || ctl_addr_o !== 22'h12345) begin
            n_fail++;
            $display("FAIL single_read_hold: got valid %b data %h addr %h, required 0 f81f 012345",
                     rd_valid_o, rd_data_o, ctl_addr_o);
        end
    endtask

    task automatic test_starvation();
        int n_wr = 0;
        for (int i = 0; i < 18; i++) begin
            if (i % 9 == 8) begin
                exp_q.push_back(mk("W", 22'h3ABCD, 16'h07E0));
                exp_q.push_back(mk("D", 22'h0, 16'h0));
            end else begin
                exp_q.push_back(mk("R", 22'h00100, 16'h0));
                exp_q.push_back(mk("V", 22'h0, 16'(16'h1000 + i)));
            end
        end
        rd_addr = 22'h00100;
        wr_addr = 22'h3ABCD;
        wr_data = 16'h07E0;
        rd_req  = 1'b1;
        wr_req  = 1'b1;
        for (int i = 0; i < 18; i++) begin
            bit is_wr;
            wait_gnt(4, "starve");
            is_wr = wr_gnt_o;
            if (is_wr) n_wr++;
            if (i == 17) begin
                rd_req = 1'b0;
                wr_req = 1'b0;
            end
            tick(1);
            if (is_wr) begin
                ctl_wr_ack = 1'b1;
            end else begin
                ctl_rd_valid = 1'b1;
                ctl_rd_data  = 16'(16'h1000 + i);
            end
            tick(1);
            ctl_wr_ack   = 1'b0;
            ctl_rd_valid = 1'b0;
        end
        tick(2);
        n_tests++;
        if (n_wr !== 2) begin
            n_fail++;
            $display("FAIL starve_write_count: got %0d, required 2", n_wr);
        end
    endtask

    task automatic test_busy();
        bit bad = 0;
        exp_q.push_back(mk("W", 22'h0ABCD, 16'h001F));
        exp_q.push_back(mk("D", 22'h0, 16'h0));
        ctl_busy = 1'b1;
        wr_addr  = 22'h0ABCD;
        wr_data  = 16'h001F;
        wr_req   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (ctl_wr_enable_o || ctl_rd_enable_o || wr_gnt_o) bad = 1;
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL busy_block: got a strobe while busy, required none");
        end
        ctl_busy = 1'b0;
        tick(1);
        wr_req = 1'b0;
        n_tests++;
        if (wr_gnt_o !== 1'b1 || ctl_wr_enable_o !== 1'b1 || ctl_wr_data_o !== 16'h001F) begin
            n_fail++;
            $display("FAIL busy_grant: got gnt %b en %b data %h, required 1 1 001f",
                     wr_gnt_o, ctl_wr_enable_o, ctl_wr_data_o);
        end
        tick(1);
        ctl_wr_ack = 1'b1;
        tick(1);
        ctl_wr_ack = 1'b0;
        n_tests++;
        if (wr_done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_done: got %b, required 1", wr_done_o);
        end
        tick(2);
    endtask

    task automatic test_spurious();
        ctl_wr_ack   = 1'b1;
        ctl_rd_valid = 1'b1;
        ctl_rd_data  = 16'h1111;
        tick(1);
        ctl_wr_ack   = 1'b0;
        ctl_rd_valid = 1'b0;
        n_tests++;
        if (wr_done_o !== 1'b0 || rd_valid_o !== 1'b0 || rd_data_o === 16'h1111) begin
            n_fail++;
            $display("FAIL idle_spurious: got done %b valid %b data %h, required 0 0 unchanged",
                     wr_done_o, rd_valid_o, rd_data_o);
        end
        exp_q.push_back(mk("R", 22'h2AAAA, 16'h0));
        exp_q.push_back(mk("V", 22'h0, 16'hBEEF));
        rd_addr = 22'h2AAAA;
        rd_req  = 1'b1;
        wait_gnt(0, "spurious_read");
        rd_req = 1'b0;
        tick(1);
        ctl_wr_ack = 1'b1;
        tick(1);
        ctl_wr_ack = 1'b0;
        n_tests++;
        if (wr_done_o !== 1'b0) begin
            n_fail++;
            $display("FAIL rdwait_spurious_ack: got wr_done %b, required 0", wr_done_o);
        end
        tick(2);
        ctl_rd_valid = 1'b1;
        ctl_rd_data  = 16'hBEEF;
        tick(1);
        ctl_rd_valid = 1'b0;
        n_tests++;
        if (rd_valid_o !== 1'b1 || rd_data_o !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL rdwait_after_ack: got valid %b data %h, required 1 beef", rd_valid_o, rd_data_o);
        end
        tick(2);
    endtask

    task automatic test_reset_midwrite();
        bit bad = 0;
        exp_q.push_back(mk("W", 22'h15555, 16'hCAFE));
        wr_addr = 22'h15555;
        wr_data = 16'hCAFE;
        wr_req  = 1'b1;
        wait_gnt(1, "midwrite");
        wr_req = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(1);
        n_tests++;
        if (ctl_addr_o !== 22'h0 || ctl_wr_data_o !== 16'h0 || rd_data_o !== 16'h0 || err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL midwrite_reset: got addr %h wdata %h rdata %h err %b, required 0 0 0 0",
                     ctl_addr_o, ctl_wr_data_o, rd_data_o, err_o);
        end
        tick(1);
        rst = 1'b1;
        tick(1);
        ctl_wr_ack = 1'b1;
        tick(1);
        ctl_wr_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (wr_done_o || wr_gnt_o || rd_gnt_o) bad = 1;
            tick(1);
        end
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL midwrite_late_ack: got a done or grant after reset, required none");
        end
    endtask

    task automatic test_watchdog();
        exp_q.push_back(mk("W", 22'h00042, 16'h1234));
        wr_addr = 22'h00042;
        wr_data = 16'h1234;
        wr_req  = 1'b1;
        wait_gnt(1, "watchdog_wr");
        wr_req = 1'b0;
`ifdef SDRAM_ARB_WATCHDOG_EN
        tick(254);
        n_tests++;
        if (err_o !== 1'b0) begin
            n_fail++;
            $display("FAIL wd_early: got err %b at 254 cycles, required 0", err_o);
        end
        tick(1);
        n_tests++;
        if (err_o !== 1'b1) begin
            n_fail++;
            $display("FAIL wd_expire: got err %b at 255 cycles, required 1", err_o);
        end
        exp_q.push_back(mk("R", 22'h00007, 16'h0));
        exp_q.push_back(mk("V", 22'h0, 16'h5A5A));
        rd_addr = 22'h00007;
        rd_req  = 1'b1;
        wait_gnt(0, "wd_next");
        rd_req = 1'b0;
`else
        begin
            bit bad = 0;
            tick(300);
            n_tests++;
            if (err_o !== 1'b0) begin
                n_fail++;
                $display("FAIL nowd_err: got err %b, required 0", err_o);
            end
            exp_q.push_back(mk("D", 22'h0, 16'h0));
            exp_q.push_back(mk("R", 22'h00007, 16'h0));
            exp_q.push_back(mk("V", 22'h0, 16'h5A5A));
            rd_addr = 22'h00007;
            rd_req  = 1'b1;
            for (int i = 0; i < 5; i++) begin
                tick(1);
                if (rd_gnt_o) bad = 1;
            end
            n_tests++;
            if (bad) begin
                n_fail++;
                $display("FAIL nowd_still_waiting: got rd_gnt during WR_WAIT, required none");
            end
            ctl_wr_ack = 1'b1;
            tick(1);
            ctl_wr_ack = 1'b0;
            n_tests++;
            if (wr_done_o !== 1'b1) begin
                n_fail++;
                $display("FAIL nowd_done: got %b, required 1", wr_done_o);
            end
            wait_gnt(0, "nowd_next");
            rd_req = 1'b0;
        end
`endif
        tick(1);
        ctl_rd_valid = 1'b1;
        ctl_rd_data  = 16'h5A5A;
        tick(1);
        ctl_rd_valid = 1'b0;
        n_tests++;
        if (rd_valid_o !== 1'b1 || rd_data_o !== 16'h5A5A) begin
            n_fail++;
            $display("FAIL wd_next_read: got valid %b data %h, required 1 5a5a", rd_valid_o, rd_data_o);
        end
        tick(2);
    endtask

    task automatic test_drain();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d outstanding events, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_starvation();
        test_busy();
        test_spurious();
        test_reset_midwrite();
        test_watchdog();
        test_drain();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_access_arbiter.md
# sdram_access_arbiter

Arbitrates the single command port of `sdram_controller` between the TFT line-fetch reader (read requester) and the user-pixel FIFO writer (write requester). Issues one SDRAM transaction at a time, returns read data or write completion to the owner, and favours display reads while bounding write starvation. Sits between the TFT timing/fetch logic and `sdram_controller`, replacing the ad-hoc enable muxing in the display path.

## Interface
- `ADDR_W`, 22, SDRAM word address width ({page, row, col})
- `DATA_W`, 16, data width (RGB565)
- `STARVE_MAX`, 8, consecutive read grants allowed while a write is pending (1..15)
- `WD_CYCLES`, 255, watchdog limit in clk cycles for a transaction (only with `SDRAM_ARB_WATCHDOG_EN`)

- `clk`  in  1  system clock
- `rst`  in  1  reset, asynchronous, active-low
- `rd_req`  in  1  read request, held until `rd_gnt`
- `rd_addr`  in  ADDR_W  read address, stable while `rd_req`
- `rd_gnt`  out  1  one-cycle pulse: read accepted
- `rd_data`  out  DATA_W  read data, valid with `rd_valid`, held afterwards
- `rd_valid`  out  1  one-cycle pulse: `rd_data` valid
- `wr_req`  in  1  write request, held until `wr_gnt`
- `wr_addr`  in  ADDR_W  write address
- `wr_data`  in  DATA_W  write data
- `wr_gnt`  out  1  one-cycle pulse: write accepted (FIFO may pop)
- `wr_done`  out  1  one-cycle pulse: controller committed write
- `ctl_busy`  in  1  controller cannot accept a command
- `ctl_rd_enable`  out  1  one-cycle read command strobe
- `ctl_wr_enable`  out  1  one-cycle write command strobe
- `ctl_addr`  out  ADDR_W  command address, held until next issue
- `ctl_wr_data`  out  DATA_W  write data, held until next issue
- `ctl_rd_valid`  in  1  controller read-data strobe
- `ctl_rd_data`  in  DATA_W  controller read data
- `ctl_wr_ack`  in  1  controller write-commit strobe
- `err`  out  1  sticky watchdog error

## Operation
- FSM states: IDLE, RD_WAIT, WR_WAIT.
- IDLE: at an edge with `ctl_busy`=0 and any request, select winner; register strobe, `*_gnt`, `ctl_addr` (and `ctl_wr_data`); move to RD_WAIT/WR_WAIT. No request or `ctl_busy`=1: stay.
- Winner: write if `wr_req` and (`!rd_req` or `starve`==STARVE_MAX); else read.
- `starve` (4 bit): +1 on each read grant while `wr_req`=1, saturating at STARVE_MAX; cleared on write grant; unchanged otherwise.
- RD_WAIT: on `ctl_rd_valid`, capture `ctl_rd_data` into `rd_data`, pulse `rd_valid`, go IDLE. `ctl_wr_ack` ignored.
- WR_WAIT: on `ctl_wr_ack`, pulse `wr_done`, go IDLE. `ctl_rd_valid` ignored.
- Strobes/acks arriving in IDLE are ignored.
- Reset (any time, incl. mid-transaction): state IDLE; `starve`, `err`, all strobes/pulses, `ctl_addr`, `ctl_wr_data`, `rd_data` = 0. In-flight controller completions are then dropped per IDLE rule.

## Timing
- Grant latency: request and `!ctl_busy` sampled at edge N -> `*_gnt` and `ctl_*_enable` high cycle N..N+1, exactly one cycle.
- Completion: `ctl_rd_valid`/`ctl_wr_ack` at edge M -> `rd_valid`/`wr_done` high for one cycle after M; `rd_data` updated same edge.
- Next grant earliest at edge M+1 (one IDLE cycle between transactions).
- Requester must drop `*_req` the cycle after `*_gnt` unless it has a new transaction; a still-high request is treated as new.
- `ctl_addr`/`ctl_wr_data` stable from issue until next issue.

## Configuration
- `SDRAM_ARB_WATCHDOG_EN` defined: counter runs in RD_WAIT/WR_WAIT, cleared on entry; reaching WD_CYCLES without completion sets `err`=1 (sticky until reset), returns to IDLE, no `rd_valid`/`wr_done`. Completion on the same edge as expiry wins (no error).
- Undefined: no counter, `err` tied 0, WAIT states wait indefinitely.

## Structure
- `sdram_arb_pkg`: state enum (IDLE, RD_WAIT, WR_WAIT), default ADDR_W/DATA_W, starve counter width.
- One sub-module `sdram_arb_watchdog` (clear/enable/expire counter), instantiated only under the macro.

## Test plan
- Single read: `rd_req`, addr 0x12345, `ctl_rd_valid` 3 cycles after strobe with 0xF81F -> one `rd_gnt`, `ctl_addr`=0x12345, `rd_valid` with `rd_data`=0xF81F.
- Simultaneous `rd_req`/`wr_req` held, STARVE_MAX=8 -> 8 read grants then 1 write grant, `starve` back to 0, repeat pattern.
- `ctl_busy`=1 for 10 cycles with `wr_req` -> no strobe; grant the cycle after busy drops, `ctl_wr_data`=`wr_data`.
- Spurious `ctl_wr_ack` in RD_WAIT and in IDLE -> no `wr_done`, state unchanged.
- Reset asserted in WR_WAIT, ack arrives after release -> all outputs 0, no `wr_done`.
- Watchdog (macro on, WD_CYCLES=255): no completion -> `err`=1 after 255 cycles, IDLE, next request granted; macro off -> stays WR_WAIT, `err`=0.
